rv32i_regfile_mp: RTL and testbench

Parametrised successor to the RV32I register file. Provides a configurable number of synchronous read ports, one write port, and a PC register.
Adds write-first bypass, a hard-wired zero for x0, and a post-reset clear sequencer that zeroes every register before the core may use the file.
Sits between decode/execute and writeback in the rv32i core.

---
 rtl/rv32i_regfile_mp_if.sv | 30 +++
 rtl/rv32i_regfile_mp.sv | 110 +++++++++++
 tb/tb_rv32i_regfile_mp.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_regfile_mp_if.sv
// Register-file bus: write port, parameterised read ports, PC control and ready status.
// The slave modport is the register file; the master modport is the core side.
interface rv32i_regfile_mp_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_BITS   = 5,
    parameter int unsigned READ_PORTS = 2
);
    logic                             write_i;
    logic [REG_BITS-1:0]              rd_addr_i;
    logic [XLEN-1:0]                  data_i;
    logic [READ_PORTS*REG_BITS-1:0]   rs_addr_i;
    logic [READ_PORTS*XLEN-1:0]       rs_o;
    logic                             write_pc_i;
    logic                             increment_pc_i;
    logic [XLEN-1:0]                  data_pc_i;
    logic [XLEN-1:0]                  pc_o;
    logic                             ready_o;

    modport slave (
        input  write_i, rd_addr_i, data_i, rs_addr_i,
        input  write_pc_i, increment_pc_i, data_pc_i,
        output rs_o, pc_o, ready_o
    );

    modport master (
        output write_i, rd_addr_i, data_i, rs_addr_i,
        output write_pc_i, increment_pc_i, data_pc_i,
        input  rs_o, pc_o, ready_o
    );
endinterface

// File: rtl/rv32i_regfile_mp.sv
// Multi-read-port RV32I register file with PC, write-first bypass, hard-wired x0
// and a post-reset sequencer that zeroes every entry before raising ready_o.
module rv32i_regfile_mp #(
    parameter int unsigned    XLEN       = 32,
    parameter int unsigned    REG_BITS   = 5,
    parameter int unsigned    READ_PORTS = 2,
    parameter int unsigned    PC_STEP    = 1,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rv32i_regfile_mp_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << REG_BITS;

    typedef enum logic {CLEAR, RUN} state_e;

    state_e                  state_q;
    logic [REG_BITS-1:0]     clr_cnt_q;
    logic [XLEN-1:0]         pc_q;
    logic                    ready_q;
    logic [READ_PORTS-1:0]   zero_q;
    logic [READ_PORTS-1:0]   byp_q;
    logic [XLEN-1:0]         byp_data_q;
    logic [XLEN-1:0]         rdata_q [READ_PORTS];
    logic [XLEN-1:0]         mem     [READ_PORTS][DEPTH];

    logic                    we;
    logic [REG_BITS-1:0]     waddr;
    logic [XLEN-1:0]         wdata;

    // The clear sequencer owns the write port until the file is ready.
    always_comb begin
        we    = 1'b0;
        waddr = clr_cnt_q;
        wdata = '0;
        if (state_q == CLEAR) begin
            we = 1'b1;
        end else begin
            we    = bus.write_i && (bus.rd_addr_i != '0);
            waddr = bus.rd_addr_i;
            wdata = bus.data_i;
        end
    end

    // One copy per read port, no reset, so each maps to a simple dual-port RAM.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < READ_PORTS; k++) begin
            if (we) begin
                mem[k][waddr] <= wdata;
            end
            rdata_q[k] <= mem[k][bus.rs_addr_i[k*REG_BITS +: REG_BITS]];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            pc_q       <= RESET_PC;
            ready_q    <= 1'b0;
            zero_q     <= '1;
            byp_q      <= '0;
            byp_data_q <= '0;
        end else begin
            byp_data_q <= bus.data_i;
            case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + REG_BITS'(1);
                    zero_q    <= '1;
                    byp_q     <= '0;
                    if (clr_cnt_q == '1) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.write_pc_i) begin
                        pc_q <= bus.data_pc_i;
                    end else if (bus.increment_pc_i) begin
                        pc_q <= pc_q + XLEN'(PC_STEP);
                    end
                    // Flags are resolved at the edge so the output mux never sees the array combinationally.
                    for (int unsigned k = 0; k < READ_PORTS; k++) begin
                        zero_q[k] <= (bus.rs_addr_i[k*REG_BITS +: REG_BITS] == '0);
                        byp_q[k]  <= we && (waddr == bus.rs_addr_i[k*REG_BITS +: REG_BITS]);
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    always_comb begin
        bus.rs_o = '0;
        for (int unsigned k = 0; k < READ_PORTS; k++) begin
            if (zero_q[k]) begin
                bus.rs_o[k*XLEN +: XLEN] = '0;
            end else if (byp_q[k]) begin
                bus.rs_o[k*XLEN +: XLEN] = byp_data_q;
            end else begin
                bus.rs_o[k*XLEN +: XLEN] = rdata_q[k];
            end
        end
    end

    assign bus.pc_o    = pc_q;
    assign bus.ready_o = ready_q;

endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// Directed bench for rv32i_regfile_mp: clear sequence, read/write table, x0, bypass, PC wrap, async reset.
module tb_rv32i_regfile_mp;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    rv32i_regfile_mp_if #(.XLEN(32), .REG_BITS(5), .READ_PORTS(2)) bus ();

    rv32i_regfile_mp #(
        .XLEN(32), .REG_BITS(5), .READ_PORTS(2), .PC_STEP(4), .RESET_PC(RST_PC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.write_i        = 1'b0;
        bus.rd_addr_i      = '0;
        bus.data_i         = '0;
        bus.rs_addr_i      = '0;
        bus.write_pc_i     = 1'b0;
        bus.increment_pc_i = 1'b0;
        bus.data_pc_i      = '0;
    endtask

    // Counts edges from reset release to ready_o, checking clear-state outputs each cycle.
    task automatic wait_clear(input string tag);
        int cycles;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cycles++;
            if (bus.ready_o) break;
            check({tag, "_pc_in_clear"}, bus.pc_o, RST_PC);
            check({tag, "_rs0_in_clear"}, bus.rs_o[31:0], 32'h0);
        end
        check({tag, "_clear_cycles"}, 32'(cycles), 32'd32);
        check({tag, "_pc_at_ready"}, bus.pc_o, RST_PC);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        rst = 1'b1;

        vecs[0] = '{1'b1, 5'd5,  32'h1234_5678, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'h1234_5678, 32'h1234_5678};
        vecs[2] = '{1'b1, 5'd6,  32'h0000_0011, 5'd3,  5'd3,  32'h0,         32'h0};
        vecs[3] = '{1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd6,  32'hA5A5_A5A5, 32'h0000_0011};
        vecs[4] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd7,  32'h0,         32'hA5A5_A5A5};
        vecs[5] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0,         32'h1234_5678};
        vecs[6] = '{1'b1, 5'd31, 32'hDEAD_BEEF, 5'd31, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[7] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd1,  32'hDEAD_BEEF, 32'h0};
        vecs[8] = '{1'b1, 5'd5,  32'hCAFE_F00D, 5'd5,  5'd5,  32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[9] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd7,  32'hCAFE_F00D, 32'hA5A5_A5A5};

        #2;
        check("reset_ready", 32'(bus.ready_o), 32'h0);
        check("reset_pc", bus.pc_o, RST_PC);
        check("reset_rs", bus.rs_o[31:0] | bus.rs_o[63:32], 32'h0);

        // Writes and PC commands during clear must be ignored.
        bus.write_i        = 1'b1;
        bus.rd_addr_i      = 5'd3;
        bus.data_i         = 32'h0000_DEAD;
        bus.write_pc_i     = 1'b1;
        bus.data_pc_i      = 32'h0000_0055;
        bus.increment_pc_i = 1'b1;
        step();
        step();
        rst = 1'b0;
        wait_clear("clr1");
        idle_inputs();

        for (int i = 0; i < 10; i++) begin
            bus.write_i   = vecs[i].wr;
            bus.rd_addr_i = vecs[i].rd;
            bus.data_i    = vecs[i].data;
            bus.rs_addr_i = {vecs[i].rs1, vecs[i].rs0};
            step();
            check($sformatf("vec%0d_rs0", i), bus.rs_o[31:0],  vecs[i].exp0);
            check($sformatf("vec%0d_rs1", i), bus.rs_o[63:32], vecs[i].exp1);
        end
        idle_inputs();

        // PC: load wins over increment, then wrap with step 4.
        bus.write_pc_i     = 1'b1;
        bus.increment_pc_i = 1'b1;
        bus.data_pc_i      = 32'hFFFF_FFF8;
        step();
        check("pc_load_priority", bus.pc_o, 32'hFFFF_FFF8);
        bus.write_pc_i = 1'b0;
        step();
        check("pc_inc1", bus.pc_o, 32'hFFFF_FFFC);
        step();
        check("pc_wrap", bus.pc_o, 32'h0000_0000);
        bus.increment_pc_i = 1'b0;
        step();
        check("pc_hold", bus.pc_o, 32'h0000_0000);
        bus.write_pc_i = 1'b1;
        bus.data_pc_i  = 32'h0000_0040;
        step();
        check("pc_load40", bus.pc_o, 32'h0000_0040);
        bus.write_pc_i = 1'b0;
        bus.rs_addr_i  = {5'd0, 5'd5};
        step();
        check("x5_before_reset", bus.rs_o[31:0], 32'hCAFE_F00D);

        // Asynchronous reset between edges.
        #3;
        rst = 1'b1;
        #1;
        check("async_pc", bus.pc_o, RST_PC);
        check("async_ready", 32'(bus.ready_o), 32'h0);
        check("async_rs0", bus.rs_o[31:0], 32'h0);
        step();
        rst = 1'b0;
        wait_clear("clr2");
        bus.rs_addr_i = {5'd31, 5'd5};
        step();
        check("x5_after_clear", bus.rs_o[31:0], 32'h0);
        check("x31_after_clear", bus.rs_o[63:32], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
